// File: rtl/pipeline_id_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_id_pkg                                               |
// | Purpose  : Shared definitions for the instruction-decode stage: ALU      |
// |            opcode width and codes, instruction field positions, the      |
// |            decoded-field record and small decode helpers.                 |
// | Macros   : ALU_OPCODE_WIDTH (defaults to 4 when not supplied)             |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`endif

package pipeline_id_pkg;

    localparam int ALU_W = `ALU_OPCODE_WIDTH;

    // ALU operation codes carried to EX in instr[29:26].
    typedef enum logic [ALU_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_SLL  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8,
        ALU_SLTU = 4'h9,
        ALU_LUI  = 4'hA,
        ALU_PASS = 4'hF
    } alu_op_e;

    // Instruction field positions.
    localparam int IMM_SEL_BIT = 31;
    localparam int ALU_OP_HI   = 29;
    localparam int ALU_OP_LO   = 26;
    localparam int RD_HI       = 25;
    localparam int RD_LO       = 21;
    localparam int RS1_HI      = 20;
    localparam int RS1_LO      = 16;
    localparam int RS2_HI      = 15;
    localparam int RS2_LO      = 11;
    localparam int IMM_HI      = 15;
    localparam int IMM_LO      = 0;

    // Decoded view of one instruction word. rs2 and imm16 overlap in the
    // encoding; the consumer picks one using imm_sel.
    typedef struct packed {
        logic             imm_sel;
        logic [ALU_W-1:0] alu_op;
        logic [4:0]       rd;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [15:0]      imm16;
    } id_fields_t;

    function automatic id_fields_t decode_fields(input logic [31:0] word);
        id_fields_t f;
        f.imm_sel = word[IMM_SEL_BIT];
        f.alu_op  = word[ALU_OP_HI:ALU_OP_LO];
        f.rd      = word[RD_HI:RD_LO];
        f.rs1     = word[RS1_HI:RS1_LO];
        f.rs2     = word[RS2_HI:RS2_LO];
        f.imm16   = word[IMM_HI:IMM_LO];
        return f;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_regfile                                              |
// | Purpose  : 32 x 32-bit register file, two asynchronous read ports and    |
// |            one synchronous write port. R0 always reads zero and ignores   |
// |            writes. All registers clear on asynchronous active-low reset.  |
// | Macros   : PIPELINE_ID_FORWARD_EN - when defined, a read of the register  |
// |            being written this cycle returns the write data (bypass).      |
// | Ports    : clk, rst (async, active low)                                  |
// |            rs1_addr/rs1_data, rs2_addr/rs2_data - read ports             |
// |            wr_en, wr_addr, wr_data               - write port            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

module pipeline_regfile (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr,
    output logic [31:0] rs1_data,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs2_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data
);

    localparam int C_NREGS = 32;

    logic [31:0] r_regs [0:C_NREGS-1];
    logic        w_wr_live;

    // A write to R0 is dropped here so r_regs[0] stays at its reset value.
    assign w_wr_live = wr_en && (wr_addr != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_live) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr,
                                              input logic [31:0] stored);
        logic [31:0] v;
        v = (addr == 5'd0) ? 32'd0 : stored;
`ifdef PIPELINE_ID_FORWARD_EN
        // Write-through: the reader sees this cycle's write data.
        if (w_wr_live && (wr_addr == addr)) begin
            v = wr_data;
        end
`endif
        return v;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr, r_regs[rs1_addr]);
        rs2_data = read_port(rs2_addr, r_regs[rs2_addr]);
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_id.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pipeline_id                                                   |
// | Purpose  : Instruction-decode stage. Decodes the fetched word, reads the  |
// |            operands from the register file and holds them in a           |
// |            valid/ready output register for EX.                           |
// | Macros   : PIPELINE_ID_FORWARD_EN - enables write-through bypass in the   |
// |            register file. ALU_OPCODE_WIDTH - opcode width (default 4).    |
// | Ports    : clk, rst (async, active low)                                  |
// |            in_valid, in_ready, instr, flush          - fetch side        |
// |            wb_en, wb_addr, wb_data                   - writeback port    |
// |            out_valid, out_ready, alu_opcode, src1,                       |
// |            src2, rd                                  - EX side           |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

`ifndef ALU_OPCODE_WIDTH
`define ALU_OPCODE_WIDTH 4
`endif

module pipeline_id
    import pipeline_id_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [31:0]                  instr,
    input  logic                         flush,
    input  logic                         wb_en,
    input  logic [4:0]                   wb_addr,
    input  logic [31:0]                  wb_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [`ALU_OPCODE_WIDTH-1:0] alu_opcode,
    output logic [31:0]                  src1,
    output logic [31:0]                  src2,
    output logic [4:0]                   rd
);

    id_fields_t   w_f;
    logic [31:0]  w_rs1_data;
    logic [31:0]  w_rs2_data;
    logic [31:0]  w_src2;
    logic         w_in_ready;
    logic         w_xfer;
    logic         w_unused_bit30;

    logic                         r_out_valid;
    logic [`ALU_OPCODE_WIDTH-1:0] r_alu_opcode;
    logic [31:0]                  r_src1;
    logic [31:0]                  r_src2;
    logic [4:0]                   r_rd;

    // Bit 30 is reserved in the encoding.
    assign w_unused_bit30 = instr[30];

    assign w_f = decode_fields(instr);

    pipeline_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (w_f.rs1),
        .rs1_data (w_rs1_data),
        .rs2_addr (w_f.rs2),
        .rs2_data (w_rs2_data),
        .wr_en    (wb_en),
        .wr_addr  (wb_addr),
        .wr_data  (wb_data)
    );

    assign w_src2 = w_f.imm_sel ? sext16(w_f.imm16) : w_rs2_data;

    // The output slot is free when empty or being drained this cycle.
    assign w_in_ready = !r_out_valid || out_ready;
    assign w_xfer     = in_valid && w_in_ready && !flush;

    // Operand register. Data is captured only on a transfer, so operands stay
    // frozen under back-pressure even if the register file is written meanwhile.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid  <= 1'b0;
            r_alu_opcode <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_rd         <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid  <= 1'b1;
            r_alu_opcode <= w_f.alu_op;
            r_src1       <= w_rs1_data;
            r_src2       <= w_src2;
            r_rd         <= w_f.rd;
        end else if (out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign in_ready   = w_in_ready;
    assign out_valid  = r_out_valid;
    assign alu_opcode = r_alu_opcode;
    assign src1       = r_src1;
    assign src2       = r_src2;
    assign rd         = r_rd;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_id.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pipeline_id                                                |
// | Purpose  : Self-checking bench for pipeline_id: a vector table for the   |
// |            single-cycle decode behaviour plus directed sequences for     |
// |            stall, flush and mid-transfer reset.                          |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+

module tb_pipeline_id;
    import pipeline_id_pkg::*;

`ifdef PIPELINE_ID_FORWARD_EN
    localparam logic [31:0] C_FWD_R3 = 32'd99;
`else
    localparam logic [31:0] C_FWD_R3 = 32'd7;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_opcode;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  rd;

    int errors = 0;
    int checks = 0;

    pipeline_id dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_opcode (alu_opcode),
        .src1       (src1),
        .src2       (src2),
        .rd         (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] instr;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_addr;
        logic [31:0] wb_data;
        logic        out_ready;
        logic        e_valid;
        logic        e_ready;
        logic [3:0]  e_op;
        logic [31:0] e_src1;
        logic [31:0] e_src2;
        logic [4:0]  e_rd;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] mk_r(input logic [3:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [4:0] s2);
        return {1'b0, 1'b0, op, d, s1, s2, 11'd0};
    endfunction

    function automatic logic [31:0] mk_i(input logic [3:0] op, input logic [4:0] d,
                                         input logic [4:0] s1, input logic [15:0] imm);
        return {1'b1, 1'b0, op, d, s1, imm};
    endfunction

    function automatic vec_t mkv(input logic iv, input logic [31:0] ins,
                                 input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic ev, input logic [3:0] eop,
                                 input logic [31:0] es1, input logic [31:0] es2,
                                 input logic [4:0] erd);
        vec_t v;
        v.in_valid = iv;  v.instr = ins;  v.flush = 1'b0;
        v.wb_en = we;     v.wb_addr = wa; v.wb_data = wd;
        v.out_ready = 1'b1;
        v.e_valid = ev;   v.e_ready = 1'b1;
        v.e_op = eop;     v.e_src1 = es1; v.e_src2 = es2; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [3:0] op,
                           input logic [31:0] s1, input logic [31:0] s2, input logic [4:0] d);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ev});
        chk({tag, ".alu_opcode"}, {28'd0, alu_opcode}, {28'd0, op});
        chk({tag, ".src1"}, src1, s1);
        chk({tag, ".src2"}, src2, s2);
        chk({tag, ".rd"}, {27'd0, rd}, {27'd0, d});
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins, input logic fl,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic ordy);
        in_valid = iv; instr = ins; flush = fl;
        wb_en = we; wb_addr = wa; wb_data = wd; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held_s1, held_s2;
        logic [31:0] i2, i3;

        // R3=7, R4=5 preload, then decode with register and immediate operands.
        vecs[0] = mkv(1'b0, 32'd0, 1'b1, 5'd3, 32'd7, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        vecs[1] = mkv(1'b0, 32'd0, 1'b1, 5'd4, 32'd5, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        vecs[2] = mkv(1'b1, mk_r(ALU_ADD, 5'd2, 5'd3, 5'd4), 1'b0, 5'd0, 32'd0,
                      1'b1, ALU_ADD, 32'd7, 32'd5, 5'd2);
        vecs[3] = mkv(1'b1, mk_i(ALU_SUB, 5'd9, 5'd0, 16'hFFFE), 1'b0, 5'd0, 32'd0,
                      1'b1, ALU_SUB, 32'd0, 32'hFFFF_FFFE, 5'd9);
        vecs[4] = mkv(1'b1, mk_i(ALU_OR, 5'd31, 5'd4, 16'h7FFF), 1'b0, 5'd0, 32'd0,
                      1'b1, ALU_OR, 32'd5, 32'h0000_7FFF, 5'd31);
        // Write 55 to R0 alongside a read of R0: must still read zero.
        vecs[5] = mkv(1'b1, mk_r(ALU_XOR, 5'd1, 5'd0, 5'd0), 1'b1, 5'd0, 32'd55,
                      1'b1, ALU_XOR, 32'd0, 32'd0, 5'd1);
        vecs[6] = mkv(1'b1, mk_r(ALU_SLT, 5'd5, 5'd3, 5'd0), 1'b0, 5'd0, 32'd0,
                      1'b1, ALU_SLT, 32'd7, 32'd0, 5'd5);
        vecs[7] = mkv(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, ALU_SLT, 32'd7, 32'd0, 5'd5);
        // Write R3=99 on the same edge as a transfer reading R3.
        vecs[8] = mkv(1'b1, mk_r(ALU_SRA, 5'd8, 5'd3, 5'd4), 1'b1, 5'd3, 32'd99,
                      1'b1, ALU_SRA, C_FWD_R3, 32'd5, 5'd8);
        vecs[9] = mkv(1'b1, mk_r(ALU_AND, 5'd6, 5'd3, 5'd4), 1'b0, 5'd0, 32'd0,
                      1'b1, ALU_AND, 32'd99, 32'd5, 5'd6);

        // Reset state.
        rst = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        #2;
        chk_out("reset", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].in_valid, vecs[i].instr, vecs[i].flush, vecs[i].wb_en,
                  vecs[i].wb_addr, vecs[i].wb_data, vecs[i].out_ready);
            tick();
            chk($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d.in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ready});
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d.alu_opcode", i), {28'd0, alu_opcode}, {28'd0, vecs[i].e_op});
                chk($sformatf("vec%0d.src1", i), src1, vecs[i].e_src1);
                chk($sformatf("vec%0d.src2", i), src2, vecs[i].e_src2);
                chk($sformatf("vec%0d.rd", i), {27'd0, rd}, {27'd0, vecs[i].e_rd});
            end
        end

        // Stall: vec9 result held while a second instruction waits; R4 is
        // rewritten during the stall and must not disturb the held operands.
        held_s1 = 32'd99;
        held_s2 = 32'd5;
        i2 = mk_i(ALU_LUI, 5'd7, 5'd4, 16'h1234);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, i2, 1'b0, (c == 0), 5'd4, 32'd77, 1'b0);
            #1;
            chk($sformatf("stall%0d.in_ready", c), {31'd0, in_ready}, 32'd0);
            tick();
            chk_out($sformatf("stall%0d", c), 1'b1, ALU_AND, held_s1, held_s2, 5'd6);
        end
        drive(1'b1, i2, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        #1;
        chk("resume.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("resume", 1'b1, ALU_LUI, 32'd77, 32'h0000_1234, 5'd7);

        // Flush with a held result and a concurrent offer.
        i3 = mk_r(ALU_SUB, 5'd12, 5'd3, 5'd3);
        drive(1'b1, i3, 1'b1, 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        chk_out("flush", 1'b0, ALU_LUI, 32'd77, 32'h0000_1234, 5'd7);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        chk("post_flush.out_valid", {31'd0, out_valid}, 32'd0);

        // Reset asserted between edges with a result held.
        drive(1'b1, mk_r(ALU_ADD, 5'd10, 5'd3, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
        tick();
        chk_out("pre_rst", 1'b1, ALU_ADD, 32'd99, 32'd77, 5'd10);
        #3;
        rst = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        chk("async_rst.in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("rst_hold.out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, mk_r(ALU_ADD, 5'd10, 5'd3, 5'd4), 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
        tick();
        chk_out("post_rst", 1'b1, ALU_ADD, 32'd0, 32'd0, 5'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipeline_id.md
PIPELINE_ID -- requirements
Module: pipeline_id

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-low reset.
REQ-003: in_valid  input  1  fetch stage presents a valid instruction.
REQ-004: in_ready  output  1  stage accepts the instruction this cycle.
REQ-005: instr  input  32  instruction word.
REQ-006: flush  input  1  discard held output and any instruction offered this cycle.
REQ-007: wb_en  input  1  register-file write enable from writeback.
REQ-008: wb_addr  input  5  write register index.
REQ-009: wb_data  input  32  write data.
REQ-010: out_valid  output  1  EX operands valid.
REQ-011: out_ready  input  1  EX accepts operands.
REQ-012: alu_opcode  output  `ALU_OPCODE_WIDTH  ALU operation for EX.
REQ-013: src1, src2  output  32 each  EX operands.
REQ-014: rd  output  5  destination register carried to writeback.

Function
REQ-015: instr fields SHALL be: [31] imm_sel, [29:26] alu op, [25:21] rd, [20:16] rs1, [15:11] rs2, [15:0] imm16.
REQ-016: alu_opcode SHALL equal instr[29:26]; src1 SHALL equal R[rs1]; src2 SHALL equal sign-extended imm16 when imm_sel=1, else R[rs2].
REQ-017: register file SHALL be 32x32, two read ports and one write port; R0 reads 0; writes to R0 are ignored.
REQ-018: a write with wb_en=1 SHALL update R[wb_addr] on the rising edge, independent of the handshake and of flush.
REQ-019: in_ready SHALL equal (!out_valid || out_ready); it is combinational.
REQ-020: transfer SHALL occur when in_valid && in_ready && !flush; the output register loads at that edge (latency 1 cycle) and out_valid becomes 1.
REQ-021: when out_valid && out_ready and no new transfer occurs, out_valid SHALL become 0.
REQ-022: while out_valid && !out_ready, all outputs SHALL hold stable; later register writes do not alter the held operands.
REQ-023: flush=1 SHALL clear out_valid at the next edge and block the concurrent transfer; flush has priority over in_valid.
REQ-024: back-to-back transfers at one per cycle SHALL be sustained when out_ready stays 1.

Reset
REQ-025: when rst=0, the block SHALL immediately set out_valid=0, alu_opcode=0, src1=0, src2=0, rd=0, and all registers to 0.
REQ-026: an assertion mid-transfer SHALL drop the transfer; in_ready is 1 during reset.
REQ-027: the first transfer SHALL be possible at the first rising edge after rst deasserts.

Configuration
REQ-028: macro PIPELINE_ID_FORWARD_EN SHALL enable write-through bypass.
REQ-029: when defined, a read of rsN during a transfer edge with wb_en=1, wb_addr==rsN and wb_addr!=0 SHALL return wb_data.
REQ-030: when undefined, that read SHALL return the pre-write register value; the write becomes visible from the next transfer.

Structure
REQ-031: define.h SHALL hold `ALU_OPCODE_WIDTH (3:0), the ALU_* opcode codes, and the instr field position constants.
REQ-032: the register file SHALL be a sub-module pipeline_regfile (2R1W, R0 hardwired to zero, bypass under PIPELINE_ID_FORWARD_EN); decode and the handshake register stay in pipeline_id.

Verification
REQ-033: preload R3=7, R4=5 via wb; instr op=ALU_ADD, rd=2, rs1=3, rs2=4, imm_sel=0, out_ready=1 -> next cycle out_valid=1, src1=7, src2=5, rd=2, alu_opcode=ALU_ADD.
REQ-034: imm_sel=1, imm16=0xFFFE, rs1=0 -> src1=0, src2=0xFFFFFFFE.
REQ-035: out_ready=0 for 3 cycles with a second instruction offered -> in_ready=0, outputs unchanged, second instruction accepted on the cycle out_ready returns to 1.
REQ-036: wb_en=1, wb_addr=3, wb_data=99 on the same edge as a transfer reading rs1=3 -> src1=99 with PIPELINE_ID_FORWARD_EN defined, src1=old R3 without it.
REQ-037: flush=1 with out_valid=1 and in_valid=1 -> out_valid=0 next cycle and the offered instruction is not issued; write to R0 with 55 then read R0 -> 0.
REQ-038: assert rst=0 between edges while out_valid=1 -> out_valid=0 immediately, all registers read 0 after release.
